// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN
    } pll_seq_state_t;

    localparam int unsigned DEF_PLL_RST_CYC      = 8;
    localparam int unsigned DEF_LOCK_STABLE_CYC  = 64;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 100000;
    localparam int unsigned DEF_RETRY_W          = 4;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments are what make this two stages; blocking would collapse it to one.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, qualifies lock, then releases the system reset; re-runs on loss of lock.
// Optional lock-wait timeout with retry counting is enabled by defining PLL_LOCK_TIMEOUT_EN.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYC      = DEF_PLL_RST_CYC,
    parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int unsigned RETRY_W          = DEF_RETRY_W
) (
    input  logic               CLK_in_100MHz,
    input  logic               reset,
    input  logic               pll_locked_in,
    input  logic               lock_lost_clr,
    output logic               pll_reset_out,
    output logic               rst_sys_out,
    output logic               ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int unsigned CNT_W =
        $clog2(max3(PLL_RST_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC) + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    pll_seq_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;
    logic             timeout_hit;

    sync_2ff u_lock_sync (
        .clk   (CLK_in_100MHz),
        .reset (reset),
        .d     (pll_locked_in),
        .q     (lock_s)
    );

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);

    // A lock seen on the timeout cycle wins; the FSM checks lock_s first.
    assign timeout_hit = (state == S_WAIT_LOCK) && !lock_s && (cnt == TIMEOUT_LAST);

    always_ff @(posedge CLK_in_100MHz) begin
        if (reset) begin
            retry_cnt <= '0;
        end else if (timeout_hit && (retry_cnt != '1)) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign retry_cnt   = '0;
`endif

    // Outputs are loaded alongside the state so they move on the same edge as it does.
    always_ff @(posedge CLK_in_100MHz) begin
        if (reset) begin
            state         <= S_PLL_RST;
            cnt           <= '0;
            pll_reset_out <= 1'b1;
            rst_sys_out   <= 1'b1;
            ready         <= 1'b0;
            lock_lost     <= 1'b0;
        end else begin
            // NOTE: the later non-blocking write wins, so a lock-loss set below overrides this clear.
            if (lock_lost_clr) begin
                lock_lost <= 1'b0;
            end

            case (state)
                S_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state         <= S_WAIT_LOCK;
                        cnt           <= '0;
                        pll_reset_out <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (timeout_hit) begin
                        state         <= S_PLL_RST;
                        cnt           <= '0;
                        pll_reset_out <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        // Without a timeout the wait is unbounded, so the count saturates.
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_STABLE: begin
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state       <= S_RUN;
                        cnt         <= '0;
                        rst_sys_out <= 1'b0;
                        ready       <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_RUN: begin
                    // Lock loss only re-qualifies; the PLL itself is reset only on timeout.
                    if (!lock_s) begin
                        state       <= S_WAIT_LOCK;
                        cnt         <= '0;
                        rst_sys_out <= 1'b1;
                        ready       <= 1'b0;
                        lock_lost   <= 1'b1;
                    end
                end

                default: begin
                    state <= S_PLL_RST;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed, table-driven bench for pll_reset_sequencer (PLL_RST=4, STABLE=8, TIMEOUT=50, RETRY_W=4).
module tb_pll_reset_sequencer;

    localparam int unsigned PLL_RST_CYC      = 4;
    localparam int unsigned LOCK_STABLE_CYC  = 8;
    localparam int unsigned LOCK_TIMEOUT_CYC = 50;
    localparam int unsigned RETRY_W          = 4;

    logic               clk;
    logic               reset;
    logic               pll_locked_in;
    logic               lock_lost_clr;
    logic               pll_reset_out;
    logic               rst_sys_out;
    logic               ready;
    logic               lock_lost;
    logic [RETRY_W-1:0] retry_cnt;

    int total = 0;
    int bad   = 0;
    int edge_no = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYC      (PLL_RST_CYC),
        .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
        .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
        .RETRY_W          (RETRY_W)
    ) dut (
        .CLK_in_100MHz (clk),
        .reset         (reset),
        .pll_locked_in (pll_locked_in),
        .lock_lost_clr (lock_lost_clr),
        .pll_reset_out (pll_reset_out),
        .rst_sys_out   (rst_sys_out),
        .ready         (ready),
        .lock_lost     (lock_lost),
        .retry_cnt     (retry_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // Each row: optional one-edge reset, else hold inputs for `cycles` edges, then check outputs.
    typedef struct {
        logic        do_reset;
        int unsigned cycles;
        logic        locked;
        logic        clr;
        logic        exp_pll;
        logic        exp_sys;
        logic        exp_rdy;
        logic        exp_lost;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic add(input logic r, input int unsigned n, input logic lk, input logic cl,
                       input logic p, input logic s, input logic rd, input logic ls);
        vecs[nvec] = '{r, n, lk, cl, p, s, rd, ls};
        nvec++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic do_reset(input logic locked);
        reset         = 1'b1;
        pll_locked_in = locked;
        lock_lost_clr = 1'b0;
        tick();
        reset   = 1'b0;
        edge_no = 0;
    endtask

    task automatic check_outs(input string tag, input logic p, input logic s,
                              input logic rd, input logic ls, input int r);
        check({tag, ".pll_reset_out"}, 32'(pll_reset_out), 32'(p));
        check({tag, ".rst_sys_out"},   32'(rst_sys_out),   32'(s));
        check({tag, ".ready"},         32'(ready),         32'(rd));
        check({tag, ".lock_lost"},     32'(lock_lost),     32'(ls));
        check({tag, ".retry_cnt"},     32'(retry_cnt),     32'(r));
    endtask

    initial begin
        reset         = 1'b1;
        pll_locked_in = 1'b0;
        lock_lost_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Basic release: lock sampled from edge 11, release at edge 21.
        add(1, 0, 0, 0,  1, 1, 0, 0);
        add(0, 3, 0, 0,  1, 1, 0, 0);
        add(0, 1, 0, 0,  0, 1, 0, 0);
        add(0, 6, 0, 0,  0, 1, 0, 0);
        add(0, 10, 1, 0, 0, 1, 0, 0);
        add(0, 1, 1, 0,  0, 0, 1, 0);
        add(0, 5, 1, 0,  0, 0, 1, 0);
        // Lock glitch during qualification: final rise sampled at edge 18, release at 28.
        add(1, 0, 0, 0,  1, 1, 0, 0);
        add(0, 10, 0, 0, 0, 1, 0, 0);
        add(0, 5, 1, 0,  0, 1, 0, 0);
        add(0, 2, 0, 0,  0, 1, 0, 0);
        add(0, 4, 1, 0,  0, 1, 0, 0);
        add(0, 6, 1, 0,  0, 1, 0, 0);
        add(0, 1, 1, 0,  0, 0, 1, 0);
        // One-cycle loss in run: seen two edges later, re-release ten edges after recovery.
        add(0, 3, 1, 0,  0, 0, 1, 0);
        add(0, 1, 0, 0,  0, 0, 1, 0);
        add(0, 1, 1, 0,  0, 0, 1, 0);
        add(0, 1, 1, 0,  0, 1, 0, 1);
        add(0, 8, 1, 0,  0, 1, 0, 1);
        add(0, 1, 1, 0,  0, 0, 1, 1);
        add(0, 1, 1, 1,  0, 0, 1, 0);
        add(0, 1, 1, 0,  0, 0, 1, 0);
        // Clear coincident with loss: set wins.
        add(0, 1, 0, 0,  0, 0, 1, 0);
        add(0, 1, 1, 0,  0, 0, 1, 0);
        add(0, 1, 1, 1,  0, 1, 0, 1);
        add(0, 1, 1, 0,  0, 1, 0, 1);
        // Reset while qualifying, then a full clean sequence with lock already held.
        add(0, 2, 1, 0,  0, 1, 0, 1);
        add(1, 0, 1, 0,  1, 1, 0, 0);
        add(0, 3, 1, 0,  1, 1, 0, 0);
        add(0, 1, 1, 0,  0, 1, 0, 0);
        add(0, 8, 1, 0,  0, 1, 0, 0);
        add(0, 1, 1, 0,  0, 0, 1, 0);

        for (int i = 0; i < nvec; i++) begin
            if (vecs[i].do_reset) begin
                do_reset(vecs[i].locked);
            end else begin
                pll_locked_in = vecs[i].locked;
                lock_lost_clr = vecs[i].clr;
                for (int c = 0; c < int'(vecs[i].cycles); c++) tick();
            end
            check_outs($sformatf("row%0d", i), vecs[i].exp_pll, vecs[i].exp_sys,
                       vecs[i].exp_rdy, vecs[i].exp_lost, 0);
        end
        lock_lost_clr = 1'b0;

`ifdef PLL_LOCK_TIMEOUT_EN
        // Lock never arrives: PLL reset re-pulses every 54 edges, retries saturate at 15.
        do_reset(1'b0);
        for (int k = 1; k <= 17; k++) begin
            while (edge_no < 54 * k - 1) tick();
            check($sformatf("to%0d.pll_before", k), 32'(pll_reset_out), 32'd0);
            tick();
            check($sformatf("to%0d.pll_pulse", k), 32'(pll_reset_out), 32'd1);
            check($sformatf("to%0d.retry", k), 32'(retry_cnt), (k > 15) ? 32'd15 : 32'(k));
            check($sformatf("to%0d.sys", k), 32'(rst_sys_out), 32'd1);
        end
        // Lock seen on the timeout cycle itself wins over the retry.
        do_reset(1'b0);
        while (edge_no < 51) tick();
        pll_locked_in = 1'b1;
        while (edge_no < 54) tick();
        check("to_edge.pll", 32'(pll_reset_out), 32'd0);
        check("to_edge.retry", 32'(retry_cnt), 32'd0);
        while (edge_no < 61) tick();
        check("to_edge.sys_held", 32'(rst_sys_out), 32'd1);
        tick();
        check("to_edge.sys_rel", 32'(rst_sys_out), 32'd0);
        check("to_edge.ready", 32'(ready), 32'd1);
`else
        // No timeout: waits indefinitely without re-pulsing, then still releases on lock.
        do_reset(1'b0);
        for (int c = 0; c < 200; c++) tick();
        check("nto.pll", 32'(pll_reset_out), 32'd0);
        check("nto.sys", 32'(rst_sys_out), 32'd1);
        check("nto.retry", 32'(retry_cnt), 32'd0);
        pll_locked_in = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        check("nto.sys_held", 32'(rst_sys_out), 32'd1);
        tick();
        check("nto.sys_rel", 32'(rst_sys_out), 32'd0);
        check("nto.ready", 32'(ready), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
